sat_frame_accumulator: RTL and testbench
========================================

Name: sat_frame_accumulator

Overview:
- Parametrised, clocked successor to the combinational saturating adder in the fixed-point datapath.
- Accumulates a frame of LEN signed W-bit samples and emits one W-bit result per frame.
- Runtime mode selects per-step saturation or two's-complement wrap; a sticky overflow flag is reported with each result.
- Sits between the sample producer and the filter output stage; uses valid/ready handshakes on both sides.

Parameters:
W, 12, sample/result width (signed two's complement, W >= 4)
LEN, 4, samples per frame (LEN >= 2)

Ports:
CLK  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-low reset (0 = reset, sampled on CLK rising edge)
Clear  input  1  synchronous frame abort, active-high
Mode  input  1  1 = saturate every partial sum, 0 = wrap modulo 2^W
In_valid  input  1  sample present on Din
In_ready  output  1  block can accept a sample this cycle
Din  input  W  signed input sample
Out_valid  output  1  Sout/Ovf hold a completed frame result
Out_ready  input  1  consumer takes result this cycle
Sout  output  W  signed frame sum
Ovf  output  1  1 = at least one partial sum of this frame exceeded range

Behaviour:
- Reset (Reset=0 at edge): state=ACC, acc=0, count=0, ovf_acc=0, Sout=0, Ovf=0, Out_valid=0. Reset overrides Clear and all handshakes, including mid-frame and with a result pending.
- States: ACC and OUT. In_ready = 1 in ACC, 0 in OUT (combinational from state).
- Accept = In_valid & In_ready. On each accept, form the W+1-bit sum s = acc + Din.
- acc is treated as 0 on the first sample of a frame (count=0).
- Saturate mode, positive overflow: s > 2^(W-1)-1 gives next = 0x7FF (W=12), flag set.
- Saturate mode, negative overflow: s < -2^(W-1) gives next = 0x800, flag set.
- Saturate mode, otherwise: next = s[W-1:0], no flag.
- Wrap mode: next = s[W-1:0]; flag is set under the same out-of-range condition but the value is not clamped.
- ovf_acc ORs the flag over the frame; it is cleared at the start of each frame.
- Accept with count < LEN-1: acc <= next, count++.
- Accept with count = LEN-1:
  - Sout <= next, Ovf <= ovf_acc | flag, Out_valid <= 1.
  - acc <= 0, count <= 0, ovf_acc <= 0, state <= OUT.
  - Latency is 1 cycle from the final accepted sample to Out_valid.
- OUT: Sout/Ovf stable while Out_valid=1. When Out_valid & Out_ready: Out_valid <= 0, state <= ACC, so a new sample is accepted in the following cycle. No input is accepted while a result is pending.
- Clear=1 (Reset=1):
  - acc, count and ovf_acc are zeroed and state <= ACC.
  - Any pending result is discarded (Out_valid <= 0); Sout/Ovf keep their values.
  - A sample presented in the same cycle is dropped.
  - Clear takes priority over Out_ready.
- Mode is sampled per accepted sample; changing it mid-frame affects only subsequent steps.
- Saturation is applied per step, not at frame end: in saturate mode, 0x7FF + 1 - 1 = 0x7FE.

Decomposition:
- Shared package sat_pkg holds:
  - SAT_MAX(W) and SAT_MIN(W) constants/functions.
  - State encoding constants ST_ACC and ST_OUT.
  - A width helper for the count register (clog2(LEN)).
- One combinational sub-module, sat_add_step (params W; inputs a, b, Mode; outputs y, flag), performs the W+1-bit add, range check and clamp/wrap. The same block is reusable elsewhere in the datapath.

Test Plan:
- Reset=0 for 2 cycles with random inputs, then Reset=1 -> Sout=0, Ovf=0, Out_valid=0, In_ready=1.
- W=12, LEN=4, Mode=1, samples 0x100,0x010,0x001,0x0FF -> Out_valid one cycle after 4th accept, Sout=0x210, Ovf=0.
- Mode=1, samples 0x7FF,0x001,0x001,0xFFE -> Sout=0x7FD, Ovf=1.
- Mode=0, same samples -> Sout=0x7FF, Ovf=1.
- Mode=1, samples 0x800,0xFFF,0x800,0x000 -> Sout=0x800, Ovf=1.
- Out_ready=0 for 5 cycles after a result -> In_ready=0 and Sout stable throughout. Out_ready=1 -> Out_valid drops, next sample accepted the following cycle.
- Clear asserted after 2 accepts (with In_valid=1), then 4 samples of 0x001 -> Sout=0x004, Ovf=0.
- Reset=0 asserted while Out_valid=1 -> all outputs return to reset values.

Source files
------------

// File: rtl/sat_frame_accumulator_pkg.sv
// sat_pkg: definitions shared by the saturating frame accumulator and its
// adder step.
//   SAT_MAX/SAT_MIN : signed range limits for a W-bit two's complement value
//   state_t         : accumulator FSM encoding (ST_ACC, ST_OUT)
//   cnt_width       : width of a counter that indexes LEN samples
package sat_pkg;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  function automatic longint SAT_MAX(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint SAT_MIN(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // A counter running 0..len-1 needs clog2(len) bits, never fewer than one.
  function automatic int cnt_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/sat_frame_accumulator_if.sv
// sat_frame_accumulator_if: sample-in / result-out handshake bundle.
//   In_valid/In_ready/Din       : sample stream into the accumulator
//   Out_valid/Out_ready/Sout/Ovf: frame result stream out of the accumulator
// Modports:
//   master : the surrounding datapath (drives samples, consumes results)
//   slave  : the accumulator itself
interface sat_frame_accumulator_if #(
  parameter int W = 12
);
  logic         In_valid;
  logic         In_ready;
  logic [W-1:0] Din;
  logic         Out_valid;
  logic         Out_ready;
  logic [W-1:0] Sout;
  logic         Ovf;

  modport master (
    output In_valid, Din, Out_ready,
    input  In_ready, Out_valid, Sout, Ovf
  );

  modport slave (
    input  In_valid, Din, Out_ready,
    output In_ready, Out_valid, Sout, Ovf
  );
endinterface

// File: rtl/sat_frame_accumulator_add_step.sv
// sat_add_step: one combinational saturating/wrapping add of two signed
// W-bit operands.
//   a, b : signed W-bit operands
//   Mode : 1 = clamp to the signed range on overflow, 0 = wrap modulo 2^W
//   y    : W-bit result
//   flag : exact sum fell outside the signed W-bit range (either mode)
module sat_add_step
  import sat_pkg::*;
#(
  parameter int W = 12
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                Mode,
  output logic signed [W-1:0] y,
  output logic                flag
);

  localparam logic signed [W:0] MAX_S = (W+1)'(SAT_MAX(W));
  localparam logic signed [W:0] MIN_S = (W+1)'(SAT_MIN(W));

  // One guard bit makes the sum exact, so the range check is a plain compare.
  logic signed [W:0] sum_full;
  assign sum_full = {a[W-1], a} + {b[W-1], b};

  always_comb begin
    y    = sum_full[W-1:0];
    flag = 1'b0;
    if (sum_full > MAX_S) begin
      flag = 1'b1;
      if (Mode) y = MAX_S[W-1:0];
    end else if (sum_full < MIN_S) begin
      flag = 1'b1;
      if (Mode) y = MIN_S[W-1:0];
    end
  end

endmodule

// File: rtl/sat_frame_accumulator.sv
// sat_frame_accumulator: sums frames of LEN signed W-bit samples, one result
// per frame, with per-step saturation or wrap selected by Mode.
//   CLK   : system clock, rising edge
//   Reset : synchronous active-low reset
//   Clear : synchronous frame abort (drops partial frame and pending result)
//   Mode  : 1 = saturate each partial sum, 0 = wrap; sampled per accepted sample
//   bus   : slave side of the sample/result handshake bundle
module sat_frame_accumulator
  import sat_pkg::*;
#(
  parameter int W   = 12,
  parameter int LEN = 4
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   Clear,
  input  logic                   Mode,
  sat_frame_accumulator_if.slave bus
);

  localparam int CW = cnt_width(LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

  state_t        state_reg, state_next;
  logic [W-1:0]  acc_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_acc_reg;
  logic [W-1:0]  sout_reg;
  logic          ovf_reg;

  logic          in_ready;
  logic          accept;
  logic          last_sample;
  logic [W-1:0]  step_a;
  logic [W-1:0]  step_y;
  logic          step_flag;

  assign accept      = bus.In_valid & in_ready;
  assign last_sample = (count_reg == LAST_IDX);
  // The first sample of a frame starts from zero regardless of acc_reg.
  assign step_a      = (count_reg == '0) ? '0 : acc_reg;

  sat_add_step #(.W(W)) u_step (
    .a    (step_a),
    .b    (bus.Din),
    .Mode (Mode),
    .y    (step_y),
    .flag (step_flag)
  );

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (!Reset) state_reg <= ST_ACC;
    else        state_reg <= state_next;
  end

  // FSM: next state. Clear wins over Out_ready and over a final accept.
  always_comb begin
    state_next = state_reg;
    if (Clear) begin
      state_next = ST_ACC;
    end else begin
      case (state_reg)
        ST_ACC:  if (accept && last_sample) state_next = ST_OUT;
        ST_OUT:  if (bus.Out_ready)         state_next = ST_ACC;
        default: state_next = ST_ACC;
      endcase
    end
  end

  // FSM: outputs. A result is pending exactly while in ST_OUT, so Out_valid
  // rises one cycle after the final sample and drops on the taking handshake.
  always_comb begin
    in_ready      = (state_reg == ST_ACC);
    bus.In_ready  = in_ready;
    bus.Out_valid = (state_reg == ST_OUT);
  end

  // Datapath: running sum, sample counter, sticky overflow and result hold.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      acc_reg     <= '0;
      count_reg   <= '0;
      ovf_acc_reg <= 1'b0;
      sout_reg    <= '0;
      ovf_reg     <= 1'b0;
    end else if (Clear) begin
      // Sout/Ovf deliberately keep their last values.
      acc_reg     <= '0;
      count_reg   <= '0;
      ovf_acc_reg <= 1'b0;
    end else if (accept) begin
      if (last_sample) begin
        sout_reg    <= step_y;
        ovf_reg     <= ovf_acc_reg | step_flag;
        acc_reg     <= '0;
        count_reg   <= '0;
        ovf_acc_reg <= 1'b0;
      end else begin
        acc_reg     <= step_y;
        count_reg   <= count_reg + CW'(1);
        ovf_acc_reg <= ovf_acc_reg | step_flag;
      end
    end
  end

  assign bus.Sout = sout_reg;
  assign bus.Ovf  = ovf_reg;

endmodule

// File: tb/tb_sat_frame_accumulator.sv
module tb_sat_frame_accumulator;

  localparam int W     = 12;
  localparam int LEN   = 4;
  localparam int SMAX  = (1 << (W - 1)) - 1;
  localparam int SMIN  = -(1 << (W - 1));
  localparam int RANGE = 1 << W;
  localparam int TMO   = 50;

  logic clk;
  logic Reset;
  logic Clear;
  logic Mode;

  sat_frame_accumulator_if #(.W(W)) bus ();

  sat_frame_accumulator #(.W(W), .LEN(LEN)) dut (
    .CLK   (clk),
    .Reset (Reset),
    .Clear (Clear),
    .Mode  (Mode),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic               mode;
    logic [LEN-1:0][W-1:0] d;
    logic [W-1:0]       sout;
    logic               ovf;
  } vec_t;

  vec_t vecs[7];

  // Reference model state: exact integer running value and sticky flag.
  int mdl_acc;
  bit mdl_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    mdl_acc = 0;
    mdl_ovf = 1'b0;
  endtask

  // Add one sample by the arithmetic rules: exact sum, then clamp or wrap.
  task automatic model_step(input logic [W-1:0] d, input logic m);
    int s;
    s = mdl_acc + int'($signed(d));
    if (s > SMAX || s < SMIN) begin
      mdl_ovf = 1'b1;
      if (m) s = (s > SMAX) ? SMAX : SMIN;
      else   s = ((s - SMIN) % RANGE + RANGE) % RANGE + SMIN;
    end
    mdl_acc = s;
  endtask

  task automatic set_vec(input int i, input logic m,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3,
                         input logic [W-1:0] s, input logic o);
    vecs[i].mode = m;
    vecs[i].d[0] = d0;
    vecs[i].d[1] = d1;
    vecs[i].d[2] = d2;
    vecs[i].d[3] = d3;
    vecs[i].sout = s;
    vecs[i].ovf  = o;
  endtask

  // Present a sample at a falling edge and return just after the rising edge
  // that accepts it.
  task automatic push(input logic [W-1:0] d, input logic m);
    int n;
    @(negedge clk);
    bus.In_valid = 1'b1;
    bus.Din      = d;
    Mode         = m;
    n = 0;
    while (!bus.In_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!bus.In_ready) check("in_ready_timeout", 32'(bus.In_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      bus.In_valid = 1'b0;
      bus.Din      = W'($urandom);
    end
  endtask

  // Called right after the final push: result must be present one cycle later.
  task automatic finish_frame(input string name, input logic [W-1:0] es, input logic eo);
    @(negedge clk);
    bus.In_valid = 1'b0;
    check({name, ".out_valid"}, 32'(bus.Out_valid), 32'd1);
    check({name, ".sout"},      32'(bus.Sout),      32'(es));
    check({name, ".ovf"},       32'(bus.Ovf),       32'(eo));
    check({name, ".in_ready"},  32'(bus.In_ready),  32'd0);
  endtask

  task automatic consume(input string name, input int delay, input logic [W-1:0] es);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({name, ".hold_valid"}, 32'(bus.Out_valid), 32'd1);
      check({name, ".hold_sout"},  32'(bus.Sout),      32'(es));
      check({name, ".hold_ready"}, 32'(bus.In_ready),  32'd0);
    end
    bus.Out_ready = 1'b1;
    @(negedge clk);
    bus.Out_ready = 1'b0;
    check({name, ".drained"}, 32'(bus.Out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".sout"},      32'(bus.Sout),      32'd0);
    check({name, ".ovf"},       32'(bus.Ovf),       32'd0);
    check({name, ".out_valid"}, 32'(bus.Out_valid), 32'd0);
    check({name, ".in_ready"},  32'(bus.In_ready),  32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    logic         m;
    string        nm;

    set_vec(0, 1'b1, 12'h100, 12'h010, 12'h001, 12'h0FF, 12'h210, 1'b0);
    set_vec(1, 1'b1, 12'h7FF, 12'h001, 12'h001, 12'hFFE, 12'h7FD, 1'b1);
    set_vec(2, 1'b0, 12'h7FF, 12'h001, 12'h001, 12'hFFE, 12'h7FF, 1'b1);
    set_vec(3, 1'b1, 12'h800, 12'hFFF, 12'h800, 12'h000, 12'h800, 1'b1);
    set_vec(4, 1'b1, 12'h7FF, 12'h001, 12'hFFF, 12'h000, 12'h7FE, 1'b1);
    set_vec(5, 1'b0, 12'h400, 12'h400, 12'h000, 12'h000, 12'h800, 1'b1);
    set_vec(6, 1'b0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFC, 1'b0);

    Reset = 1'b0; Clear = 1'b0; Mode = 1'b0;
    bus.In_valid = 1'b0; bus.Din = '0; bus.Out_ready = 1'b0;

    // Reset held for two cycles with random activity on every input.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.In_valid  = 1'($urandom);
      bus.Din       = W'($urandom);
      bus.Out_ready = 1'($urandom);
      Clear         = 1'($urandom);
      Mode          = 1'($urandom);
    end
    @(negedge clk);
    Reset = 1'b1; Clear = 1'b0; bus.In_valid = 1'b0; bus.Out_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    $display("reset released: Sout=%h Ovf=%b Out_valid=%b In_ready=%b",
             bus.Sout, bus.Ovf, bus.Out_valid, bus.In_ready);

    // Directed vector table.
    for (int v = 0; v < 7; v++) begin
      nm = $sformatf("vec%0d", v);
      for (int k = 0; k < LEN; k++) push(vecs[v].d[k], vecs[v].mode);
      finish_frame(nm, vecs[v].sout, vecs[v].ovf);
      $display("%s mode=%b -> Sout=%h Ovf=%b (expect %h %b)",
               nm, vecs[v].mode, bus.Sout, bus.Ovf, vecs[v].sout, vecs[v].ovf);
      consume(nm, 0, vecs[v].sout);
    end

    // Result stalled 5 cycles with a sample waiting; it must only be taken
    // the cycle after the drain.
    for (int k = 0; k < LEN; k++) push(vecs[0].d[k], 1'b1);
    finish_frame("stall", 12'h210, 1'b0);
    bus.In_valid = 1'b1; bus.Din = 12'h3FF; Mode = 1'b1;
    consume("stall", 5, 12'h210);
    check("stall.in_ready_after", 32'(bus.In_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k < LEN; k++) push(12'h001, 1'b1);
    finish_frame("stall_next", 12'h402, 1'b0);
    $display("stall follow-up frame -> Sout=%h Ovf=%b", bus.Sout, bus.Ovf);
    consume("stall_next", 0, 12'h402);

    // Clear after two accepts, sample offered alongside Clear is dropped.
    push(12'h100, 1'b1);
    push(12'h7FF, 1'b1);
    @(negedge clk);
    Clear = 1'b1; bus.In_valid = 1'b1; bus.Din = 12'h200;
    @(negedge clk);
    Clear = 1'b0; bus.In_valid = 1'b0;
    check("clear.in_ready", 32'(bus.In_ready), 32'd1);
    for (int k = 0; k < LEN; k++) push(12'h001, 1'b1);
    finish_frame("clear", 12'h004, 1'b0);
    $display("clear mid-frame -> Sout=%h Ovf=%b", bus.Sout, bus.Ovf);
    consume("clear", 0, 12'h004);

    // Clear while a result is pending, with Out_ready also high.
    for (int k = 0; k < LEN; k++) push(vecs[1].d[k], 1'b1);
    finish_frame("clear_pend", 12'h7FD, 1'b1);
    Clear = 1'b1; bus.Out_ready = 1'b1;
    @(negedge clk);
    Clear = 1'b0; bus.Out_ready = 1'b0;
    check("clear_pend.out_valid", 32'(bus.Out_valid), 32'd0);
    check("clear_pend.sout_kept", 32'(bus.Sout),      32'h7FD);
    check("clear_pend.ovf_kept",  32'(bus.Ovf),       32'd1);
    check("clear_pend.in_ready",  32'(bus.In_ready),  32'd1);
    $display("clear with result pending -> Out_valid=%b Sout=%h", bus.Out_valid, bus.Sout);

    // Reset while a result is pending.
    for (int k = 0; k < LEN; k++) push(vecs[1].d[k], 1'b1);
    finish_frame("rst_pend", 12'h7FD, 1'b1);
    Reset = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    check_reset_outputs("rst_pend");
    $display("reset with result pending -> Sout=%h Ovf=%b Out_valid=%b",
             bus.Sout, bus.Ovf, bus.Out_valid);

    // Reset mid-frame; the next frame must start from zero.
    push(12'h300, 1'b1);
    push(12'h300, 1'b1);
    @(negedge clk);
    bus.In_valid = 1'b0; Reset = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    for (int k = 0; k < LEN; k++) push(12'h001, 1'b0);
    finish_frame("rst_mid", 12'h004, 1'b0);
    $display("reset mid-frame -> Sout=%h Ovf=%b", bus.Sout, bus.Ovf);
    consume("rst_mid", 0, 12'h004);

    // Randomized frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      model_reset();
      for (int k = 0; k < LEN; k++) begin
        idle(int'($urandom_range(0, 2)));
        case ($urandom_range(0, 3))
          0:       d = 12'h7FF;
          1:       d = 12'h800;
          default: d = W'($urandom);
        endcase
        m = 1'($urandom);
        model_step(d, m);
        push(d, m);
      end
      nm = $sformatf("rand%0d", f);
      finish_frame(nm, W'(mdl_acc), mdl_ovf);
      $display("%s -> Sout=%h Ovf=%b (model %h %b)", nm, bus.Sout, bus.Ovf, W'(mdl_acc), mdl_ovf);
      consume(nm, int'($urandom_range(0, 3)), W'(mdl_acc));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
